// File: rtl/mod_n_count_monitor_if.sv
// mod_n_count_monitor_if
// Groups the sample/clear inputs and the reconstructed-motion outputs of
// mod_n_count_monitor.
//   master : drives i_valid, i_Q, i_clr_err; observes all o_* signals
//   slave  : the monitor itself (consumes i_*, produces o_*)
// Optional macro MON_ERR_COUNT_EN adds o_err_cnt (CNT_W bits).
interface mod_n_count_monitor_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
);
  logic             i_valid;
  logic [WIDTH-1:0] i_Q;
  logic             i_clr_err;
  logic             o_dir;
  logic             o_moving;
  logic             o_wrap;
  logic             o_dir_chg;
  logic             o_err;
  logic [CNT_W-1:0] o_run;
`ifdef MON_ERR_COUNT_EN
  logic [CNT_W-1:0] o_err_cnt;

  modport master (
    output i_valid, i_Q, i_clr_err,
    input  o_dir, o_moving, o_wrap, o_dir_chg, o_err, o_run, o_err_cnt
  );
  modport slave (
    input  i_valid, i_Q, i_clr_err,
    output o_dir, o_moving, o_wrap, o_dir_chg, o_err, o_run, o_err_cnt
  );
`else
  modport master (
    output i_valid, i_Q, i_clr_err,
    input  o_dir, o_moving, o_wrap, o_dir_chg, o_err, o_run
  );
  modport slave (
    input  i_valid, i_Q, i_clr_err,
    output o_dir, o_moving, o_wrap, o_dir_chg, o_err, o_run
  );
`endif
endinterface

// File: rtl/mod_n_count_monitor.sv
// mod_n_count_monitor
// Watches the Q value of a mod-N counter and reconstructs its motion:
// direction, stall, wrap-around, direction changes and illegal transitions.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset
//   mon    : slave modport of mod_n_count_monitor_if
//            (i_valid, i_Q, i_clr_err in; o_dir, o_moving, o_wrap,
//             o_dir_chg, o_err, o_run [, o_err_cnt] out, all registered)
// Optional macro MON_ERR_COUNT_EN: saturating count of illegal samples
// on o_err_cnt, cleared by reset and i_clr_err.
module mod_n_count_monitor #(
  parameter int WIDTH = 2,
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mod_n_count_monitor_if.slave  mon
);

  typedef enum logic {SYNC, TRACK} state_t;

  localparam logic [31:0] NU = 32'(N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_q, dir_d;
  logic             moving_q, moving_d;
  logic             wrap_q, wrap_d;
  logic             dir_chg_q, dir_chg_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] run_q, run_d;
`ifdef MON_ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

  logic [31:0] q_ext, prev_ext, up_tgt, dn_tgt;
  logic        is_up, is_dn, step_dir, err_evt;

  assign q_ext    = 32'(mon.i_Q);
  assign prev_ext = 32'(prev_q);
  assign up_tgt   = (prev_ext == NU - 32'd1) ? 32'd0 : prev_ext + 32'd1;
  assign dn_tgt   = (prev_ext == 32'd0) ? NU - 32'd1 : prev_ext - 32'd1;
  assign is_up    = (q_ext == up_tgt);
  assign is_dn    = (q_ext == dn_tgt);
  // With N==2 both neighbours coincide; keep the current direction.
  assign step_dir = (is_up && is_dn) ? dir_q : is_up;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    dir_d     = dir_q;
    moving_d  = moving_q;
    wrap_d    = 1'b0;
    dir_chg_d = 1'b0;
    err_d     = mon.i_clr_err ? 1'b0 : err_q;
    run_d     = run_q;
    err_evt   = 1'b0;
`ifdef MON_ERR_COUNT_EN
    err_cnt_d = mon.i_clr_err ? '0 : err_cnt_q;
`endif
    if (mon.i_valid) begin
      if (state_q == SYNC) begin
        if (q_ext < NU) begin
          prev_d   = mon.i_Q;
          moving_d = 1'b0;
          state_d  = TRACK;
        end else begin
          err_evt = 1'b1;
        end
      end else if (q_ext >= NU || (!is_up && !is_dn && mon.i_Q != prev_q)) begin
        // Illegal jump: resynchronise on the next in-range sample.
        err_evt  = 1'b1;
        moving_d = 1'b0;
        run_d    = '0;
        state_d  = SYNC;
      end else if (mon.i_Q == prev_q) begin
        moving_d = 1'b0;
      end else begin
        moving_d = 1'b1;
        prev_d   = mon.i_Q;
        wrap_d   = step_dir ? (prev_ext == NU - 32'd1 && q_ext == 32'd0)
                            : (prev_ext == 32'd0 && q_ext == NU - 32'd1);
        if (step_dir != dir_q) begin
          dir_d     = step_dir;
          dir_chg_d = 1'b1;
          run_d     = CNT_W'(1);
        end else if (run_q != '1) begin
          run_d = run_q + CNT_W'(1);
        end
      end
    end
    // A new error outranks a simultaneous clear.
    if (err_evt) begin
      err_d = 1'b1;
`ifdef MON_ERR_COUNT_EN
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= SYNC;
      prev_q    <= '0;
      dir_q     <= 1'b1;
      moving_q  <= 1'b0;
      wrap_q    <= 1'b0;
      dir_chg_q <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= '0;
`ifdef MON_ERR_COUNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      dir_q     <= dir_d;
      moving_q  <= moving_d;
      wrap_q    <= wrap_d;
      dir_chg_q <= dir_chg_d;
      err_q     <= err_d;
      run_q     <= run_d;
`ifdef MON_ERR_COUNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign mon.o_dir     = dir_q;
  assign mon.o_moving  = moving_q;
  assign mon.o_wrap    = wrap_q;
  assign mon.o_dir_chg = dir_chg_q;
  assign mon.o_err     = err_q;
  assign mon.o_run     = run_q;
`ifdef MON_ERR_COUNT_EN
  assign mon.o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mod_n_count_monitor.sv
// Testbench for mod_n_count_monitor (WIDTH=2, N=3, CNT_W=8).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_mod_n_count_monitor;

  localparam int WIDTH = 2;
  localparam int N     = 3;
  localparam int CNT_W = 8;
  localparam int RMAX  = 255;

  logic clk;
  logic rst;

  mod_n_count_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) mif ();

  mod_n_count_monitor #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .mon   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_synced;
  int m_prev, m_run, m_ecnt;
  bit m_dir, m_moving, m_wrap, m_chg, m_err;

  task automatic m_reset();
    m_synced = 0; m_prev = 0; m_run = 0; m_ecnt = 0;
    m_dir = 1; m_moving = 0; m_wrap = 0; m_chg = 0; m_err = 0;
  endtask

  task automatic m_illegal();
    m_err = 1;
    if (m_ecnt < RMAX) m_ecnt++;
  endtask

  task automatic mstep(input bit v, input int q, input bit c);
    bit up, dn, sd;
    m_wrap = 0;
    m_chg  = 0;
    if (c) begin
      m_err  = 0;
      m_ecnt = 0;
    end
    if (v) begin
      if (!m_synced) begin
        if (q < N) begin
          m_prev = q; m_synced = 1; m_moving = 0;
        end else begin
          m_illegal();
        end
      end else begin
        up = (q == (m_prev + 1) % N);
        dn = (q == (m_prev + N - 1) % N);
        if (q >= N || (!up && !dn && q != m_prev)) begin
          m_illegal();
          m_moving = 0; m_run = 0; m_synced = 0;
        end else if (q == m_prev) begin
          m_moving = 0;
        end else begin
          sd = (up && dn) ? m_dir : up;
          m_moving = 1;
          m_wrap = sd ? (m_prev == N - 1 && q == 0) : (m_prev == 0 && q == N - 1);
          if (sd != m_dir) begin
            m_dir = sd; m_chg = 1; m_run = 1;
          end else if (m_run < RMAX) begin
            m_run++;
          end
          m_prev = q;
        end
      end
    end
  endtask

  function automatic logic [12:0] obs();
    return {mif.o_dir, mif.o_moving, mif.o_wrap, mif.o_dir_chg, mif.o_err, mif.o_run};
  endfunction

  function automatic logic [12:0] mexp();
    return {m_dir, m_moving, m_wrap, m_chg, m_err, CNT_W'(m_run)};
  endfunction

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit v, input int q, input bit c);
    mif.i_valid   = v;
    mif.i_Q       = WIDTH'(q);
    mif.i_clr_err = c;
    @(posedge clk);
    mstep(v, q, c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    mif.i_valid = 0; mif.i_Q = '0; mif.i_clr_err = 0;
    rst = 1'b1;
    #12;
    n_checks++;
    if (obs() !== 13'b1_0_0_0_0_00000000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", obs(), 13'b1_0_0_0_0_00000000);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_up_count();
    int qs[4]  = '{0, 1, 2, 0};
    bit mv[4]  = '{0, 1, 1, 1};
    bit wr[4]  = '{0, 0, 0, 1};
    int rn[4]  = '{0, 1, 2, 3};
    logic [12:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(1, qs[i], 0);
      e = {1'b1, mv[i], wr[i], 1'b0, 1'b0, CNT_W'(rn[i])};
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL up_count[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_down_reverse();
    int qs[3] = '{2, 1, 0};
    bit ch[3] = '{1, 0, 0};
    bit wr[3] = '{1, 0, 0};
    int rn[3] = '{1, 2, 3};
    logic [12:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1, qs[i], 0);
      e = {1'b0, 1'b1, wr[i], ch[i], 1'b0, CNT_W'(rn[i])};
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL down_reverse[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_stall();
    logic [12:0] e;
    // 0 -> 1 is an up step reversing direction, then three stalls.
    drive(1, 1, 0);
    e = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, CNT_W'(1)};
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL stall_entry: got %b want %b", obs(), e);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0);
      e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(1)};
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %b want %b", i, obs(), e);
      end
    end
    // Without a strobe even a would-be step value is ignored.
    drive(0, 2, 0);
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL idle_hold: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_error();
    drive(1, 0, 0);  // 1 -> 0 down step, prev = 0
    drive(1, 3, 0);  // out of range
    n_checks++;
    if ({mif.o_moving, mif.o_err, mif.o_run} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL err_set: got mv=%b err=%b run=%0d want 0 1 0", mif.o_moving, mif.o_err, mif.o_run);
    end
    drive(1, 1, 0);  // resync, no flags
    n_checks++;
    if ({mif.o_moving, mif.o_wrap, mif.o_dir_chg, mif.o_err} !== 4'b0001) begin
      n_fail++;
      $display("FAIL err_resync: got %b want 0001", {mif.o_moving, mif.o_wrap, mif.o_dir_chg, mif.o_err});
    end
    drive(1, 2, 0);
    n_checks++;
    if ({mif.o_moving, mif.o_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 11", {mif.o_moving, mif.o_err});
    end
    drive(0, 0, 1);
    n_checks++;
    if (mif.o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", mif.o_err);
    end
    drive(1, 3, 1);  // clear together with a new error: set wins
    n_checks++;
    if (mif.o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_wins: got %b want 1", mif.o_err);
    end
    drive(0, 0, 1);
    n_checks++;
    if (mif.o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear2: got %b want 0", mif.o_err);
    end
  endtask

  task automatic test_async_reset();
    int qs[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, qs[i], 0);
    n_checks++;
    if (mif.o_run !== 8'd5) begin
      n_fail++;
      $display("FAIL run_before_reset: got %0d want 5", mif.o_run);
    end
    drive(1, 2, 0);  // stall so o_dir/o_run are meaningful
    rst = 1'b1;
    #2;              // well before the next clock edge
    n_checks++;
    if (obs() !== 13'b1_0_0_0_0_00000000) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs(), 13'b1_0_0_0_0_00000000);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 2, 0);
    n_checks++;
    if (obs() !== 13'b1_0_0_0_0_00000000) begin
      n_fail++;
      $display("FAIL post_reset_sync: got %b want %b", obs(), 13'b1_0_0_0_0_00000000);
    end
    drive(1, 0, 0);
    n_checks++;
    if (obs() !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL post_reset_step: got %b want %b", obs(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 0, 0);
    for (int i = 1; i <= 270; i++) begin
      drive(1, i % N, 0);
      if (i == 254 || i == 255 || i == 270) begin
        n_checks++;
        if (mif.o_run !== CNT_W'(i > RMAX ? RMAX : i)) begin
          n_fail++;
          $display("FAIL run_sat[%0d]: got %0d want %0d", i, mif.o_run, (i > RMAX ? RMAX : i));
        end
      end
    end
  endtask

`ifdef MON_ERR_COUNT_EN
  task automatic test_err_count();
    do_reset();
    drive(1, 0, 0);
    drive(1, 3, 0);
    drive(1, 3, 0);
    drive(1, 3, 0);
    n_checks++;
    if (mif.o_err_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL err_cnt3: got %0d want 3", mif.o_err_cnt);
    end
    drive(1, 3, 1);
    n_checks++;
    if ({mif.o_err, mif.o_err_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL err_cnt_clr_set: got err=%b cnt=%0d want 1 1", mif.o_err, mif.o_err_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int r, q;
    bit v, c;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)       q = (m_prev + 1) % N;
      else if (r < 6)  q = (m_prev + N - 1) % N;
      else if (r == 6) q = m_prev;
      else if (r == 7) q = 3;
      else             q = $urandom_range(0, 3);
      v = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 15) == 0);
      if (i == 300) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_reset();
      end
      drive(v, q, c);
      n_checks++;
      if (obs() !== mexp()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b want %b", i, obs(), mexp());
      end
`ifdef MON_ERR_COUNT_EN
      n_checks++;
      if (mif.o_err_cnt !== CNT_W'(m_ecnt)) begin
        n_fail++;
        $display("FAIL random_err_cnt[%0d]: got %0d want %0d", i, mif.o_err_cnt, m_ecnt);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0;
    m_reset();
    test_reset();
    test_up_count();
    test_down_reverse();
    test_stall();
    test_error();
    test_async_reset();
    test_saturation();
`ifdef MON_ERR_COUNT_EN
    test_err_count();
`endif
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
